bus_master_port: RTL

Master-side port of the serial system bus. It accepts one transaction command per enable from the test controller: enable, read_en, 8-bit data and 14-bit address. It then requests the bus from the arbiter and serialises the mode and address onto the bus, followed by either the write data or the read data. `request` is held high for the whole transaction, so the controller can wait for all masters to go idle. Two instances sit in the system, one per master.

---
 rtl/bus_master_port.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - master-side serial bus port: request, mode/address/data serialiser, read deserialiser
module bus_master_port #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    output logic                  request,
    input  logic                  grant,
    output logic                  bus_valid,
    output logic                  bus_tx,
    output logic                  bus_mode,
    input  logic                  slave_ready,
    input  logic                  rx_valid,
    input  logic                  bus_rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  error,
    output logic                  busy
);

    // Bit counter is shared by the address and data phases, so it is sized
    // for the longer address phase (data is assumed no wider than address).
    localparam int BW = $clog2(ADDR_WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_WIDTH - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_MODE, S_ADDR, S_WAIT, S_WDATA, S_RDATA, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] sh_q, sh_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [TW-1:0]         wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  request_q, request_d;
    logic                  valid_q, valid_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  busy_q, busy_d;
    logic                  abort;

    // Next state plus the registered output values for the cycle that follows.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wdata_d    = wdata_q;
        sh_d       = sh_q;
        bit_d      = bit_q;
        wcnt_d     = wcnt_q;
        hold_d     = hold_q;
        data_out_d = data_out_q;
        tx_d       = 1'b0;
        abort      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    mode_d  = read_en;
                    wdata_d = data_in;
                    sh_d    = addr_in;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (grant) begin
                    state_d = S_MODE;
                    tx_d    = mode_q;
                end
            end
            S_MODE: begin
                if (!grant) begin
                    abort = 1'b1;
                end else begin
                    state_d = S_ADDR;
                    tx_d    = sh_q[0];
                    sh_d    = sh_q >> 1;
                    bit_d   = '0;
                end
            end
            S_ADDR: begin
                if (!grant) begin
                    abort = 1'b1;
                end else if (bit_q == ADDR_LAST) begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end else begin
                    bit_d = bit_q + BW'(1);
                    tx_d  = sh_q[0];
                    sh_d  = sh_q >> 1;
                end
            end
            S_WAIT: begin
                if (!grant) begin
                    abort = 1'b1;
                end else if (slave_ready) begin
                    bit_d = '0;
                    if (mode_q) begin
                        state_d = S_RDATA;
                        wcnt_d  = '0;
                    end else begin
                        state_d = S_WDATA;
                        tx_d    = wdata_q[0];
                        sh_d    = ADDR_WIDTH'(wdata_q >> 1);
                    end
                end else if (wcnt_q == TO_LAST) begin
                    abort = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            S_WDATA: begin
                if (!grant) begin
                    abort = 1'b1;
                end else if (bit_q == DATA_LAST) begin
                    state_d = S_DONE;
                end else begin
                    bit_d = bit_q + BW'(1);
                    tx_d  = sh_q[0];
                    sh_d  = sh_q >> 1;
                end
            end
            S_RDATA: begin
                if (!grant) begin
                    abort = 1'b1;
                end else if (rx_valid) begin
                    wcnt_d = '0;
                    hold_d = {bus_rx, hold_q[DATA_WIDTH-1:1]};
                    if (bit_q == DATA_LAST) begin
                        state_d    = S_DONE;
                        data_out_d = hold_d;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else if (wcnt_q == TO_LAST) begin
                    abort = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_DONE;
            tx_d    = 1'b0;
        end

        valid_d   = (state_d == S_MODE) || (state_d == S_ADDR) || (state_d == S_WDATA);
        request_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        error_d   = abort;
        busy_d    = (state_d != S_IDLE);
    end

    // State and output registers; reset discards any partial transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            wdata_q    <= '0;
            sh_q       <= '0;
            bit_q      <= '0;
            wcnt_q     <= '0;
            hold_q     <= '0;
            data_out_q <= '0;
            request_q  <= 1'b0;
            valid_q    <= 1'b0;
            tx_q       <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wdata_q    <= wdata_d;
            sh_q       <= sh_d;
            bit_q      <= bit_d;
            wcnt_q     <= wcnt_d;
            hold_q     <= hold_d;
            data_out_q <= data_out_d;
            request_q  <= request_d;
            valid_q    <= valid_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
        end
    end

    assign request   = request_q;
    assign bus_valid = valid_q;
    assign bus_tx    = tx_q;
    assign bus_mode  = mode_q;
    assign data_out  = data_out_q;
    assign done      = done_q;
    assign error     = error_q;
    assign busy      = busy_q;

endmodule
